regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled only at rising clk.
- we  in  1  write-back write enable (1 = write).
- waddr  in  5  write-back destination register address.
- wdata  in  32  write-back data.
- re1  in  1  read port 1 enable, driven by the decode stage.
- raddr1  in  5  read port 1 address.
- rdata1  out  32  read port 1 data, combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 address.
- rdata2  out  32  read port 2 data, combinational.
- init_busy  out  1  1 while the post-reset clear sequence runs.

REQ-002 The block SHALL use the following parameters, listed as name, default and meaning:
- DW  32  data width.
- AW  5  address width.
- NREG  32  register count, equal to 2^AW.

Function
REQ-003 Storage SHALL be a 32 x 32 array with no reset on the array itself, so that it maps to distributed RAM; clearing is done by the init FSM.
REQ-004 The FSM SHALL have two states, INIT and RUN, plus a 5-bit clear counter cnt.
REQ-005 In INIT, on each rising clk, the block SHALL write 0 to entry cnt and increment cnt.
REQ-006 When cnt==31 in INIT, the block SHALL write entry 31 and move to RUN at the same edge; INIT therefore lasts exactly 32 cycles after rst is released.
REQ-007 init_busy SHALL be 1 in INIT and 0 in RUN, and SHALL be a registered output.
REQ-008 In RUN, at a rising clk with we=1 and waddr!=0, the block SHALL write wdata to entry waddr.
REQ-009 A write with waddr==0 SHALL be discarded; r0 reads as 0 permanently.
REQ-010 In INIT, external writes (we=1) SHALL be ignored and dropped, not queued.
REQ-011 The read ports SHALL be combinational with zero latency, and the two ports SHALL be fully independent and identical. For each port n (1 and 2), rdatan is chosen by the first matching rule, in this priority order:
- a) rst==0 -> 0.
- b) init_busy==1 -> 0.
- c) ren==0 -> 0.
- d) raddrn==0 -> 0.
- e) we==1 and waddr==raddrn -> wdata (same-cycle write-through bypass).
- f) otherwise -> array[raddrn].
REQ-012 Both ports SHALL be able to read the same address simultaneously, and both SHALL see the bypass.
REQ-013 A write SHALL become visible through the array at the cycle after its edge, and through the bypass during the write cycle itself.

Reset
REQ-014 At a rising clk with rst==0, the block SHALL set state to INIT, cnt to 0 and init_busy to 1.
REQ-015 While rst is held low, the FSM SHALL remain in INIT with cnt=0, and entry 0 SHALL be rewritten with 0 every cycle.
REQ-016 While rst==0, rdata1 and rdata2 SHALL be 0 (combinationally).
REQ-017 A reset asserted mid-INIT or mid-RUN SHALL restart the full 32-cycle clear.
REQ-018 A write presented in the same cycle as an asserted reset SHALL be lost.
REQ-019 After the clear completes, every entry SHALL read 0 until it is written.

Verification
REQ-020 Reset/init: hold rst=0 for 3 cycles, then release -> init_busy=1 for exactly 32 cycles and falls on the 32nd edge; reading all 32 addresses afterwards returns 0x00000000.
REQ-021 Write/read: in RUN, write 0xDEADBEEF to r5, then next cycle set re1=1, raddr1=5 -> rdata1=0xDEADBEEF; with re1=0 -> rdata1=0.
REQ-022 r0 immunity: in RUN, write 0xFFFFFFFF to r0, then set re1=1, raddr1=0 -> rdata1=0.
REQ-023 Bypass: r7 holds 0x11111111; in one cycle apply we=1, waddr=7, wdata=0x22222222 with re1=re2=1 and raddr1=raddr2=7 -> both ports return 0x22222222 in that same cycle; the next cycle, with we=0, both still return 0x22222222.
REQ-024 Write during INIT: apply we=1, waddr=3, wdata=0xA5A5A5A5 while init_busy=1 -> after init completes, r3 reads 0.
REQ-025 Mid-operation reset: write 0x12345678 to r9, assert rst=0 for 1 cycle at cnt=10 of a later INIT or in RUN, then let the clear complete -> r9 reads 0 and init_busy remains high for 32 cycles after rst is released.

Source files
------------

// File: rtl/regfile.sv
// Two-read/one-write register file with a post-reset clear sequence.
// Storage has no reset so it can map to distributed RAM.
module rf_rd_port #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          blocked,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] mem_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  always_comb begin
    rdata = '0;
    if (blocked || !re || raddr == '0) rdata = '0;
    else if (we && waddr == raddr)     rdata = wdata;
    else                               rdata = mem_data;
  end
endmodule

module regfile #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic          init_busy
);
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] mem [NREG];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = waddr;
    mem_wd  = wdata;
    if (!rst) begin
      // Held reset keeps rewriting entry 0; external writes are lost.
      state_d = ST_INIT;
      cnt_d   = '0;
      mem_we  = 1'b1;
      mem_wa  = '0;
      mem_wd  = '0;
    end else if (state_q == ST_INIT) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == AW'(NREG - 1)) state_d = ST_RUN;
    end else if (we && waddr != '0) begin
      mem_we = 1'b1;
    end
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign init_busy = busy_q;

  logic [1:0]         re_v;
  logic [1:0][AW-1:0] ra_v;
  logic [1:0][DW-1:0] rd_v, mem_rd;

  assign re_v = {re2, re1};
  assign ra_v = {raddr2, raddr1};

  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign mem_rd[g] = mem[ra_v[g]];
    rf_rd_port #(.DW(DW), .AW(AW)) u_port (
      .blocked  (!rst || busy_q),
      .re       (re_v[g]),
      .raddr    (ra_v[g]),
      .mem_data (mem_rd[g]),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rd_v[g])
    );
  end

  assign rdata1 = rd_v[0];
  assign rdata2 = rd_v[1];
endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table, hand sequences for init/reset, random vs model.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst, we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic        init_busy;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents plus cycles of clearing still owed.
  logic [31:0] model_mem [32];
  int          init_left = 32;
  bit          started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic ren, input logic [4:0] ra);
    if (!rst || init_left > 0 || !ren || ra == 0) return 32'h0;
    if (we && waddr == ra) return wdata;
    return model_mem[ra];
  endfunction

  // One clock: check outputs against the model, advance the model at the edge.
  task automatic cyc();
    #1;
    chk("model_rdata1", rdata1, exp_rd(re1, raddr1));
    chk("model_rdata2", rdata2, exp_rd(re2, raddr2));
    if (started) chk("model_busy", {31'b0, init_busy}, {31'b0, init_left > 0});
    @(posedge clk);
    if (!rst) begin
      init_left = 32;
    end else if (init_left > 0) begin
      model_mem[32 - init_left] = 32'h0;
      init_left--;
    end else if (we && waddr != 0) begin
      model_mem[waddr] = wdata;
    end
    started = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  typedef struct {
    logic rst, we; logic [4:0] waddr; logic [31:0] wdata;
    logic re1; logic [4:0] ra1; logic re2; logic [4:0] ra2;
    logic [31:0] e1, e2; logic eb;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                              logic [31:0] e1, logic [31:0] e2, logic eb);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
    v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
    v.e1 = e1; v.e2 = e2; v.eb = eb;
    return v;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;

    tbl[0]  = mk(1, 1, 5,  32'hDEADBEEF, 0, 5, 0, 0, 32'h0,        32'h0,        0);
    tbl[1]  = mk(1, 0, 0,  32'h0,        1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 0, 0,  32'h0,        0, 5, 0, 5, 32'h0,        32'h0,        0);
    tbl[3]  = mk(1, 1, 0,  32'hFFFFFFFF, 1, 0, 1, 0, 32'h0,        32'h0,        0);
    tbl[4]  = mk(1, 0, 0,  32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        0);
    tbl[5]  = mk(1, 1, 7,  32'h11111111, 0, 0, 0, 0, 32'h0,        32'h0,        0);
    tbl[6]  = mk(1, 0, 0,  32'h0,        1, 7, 1, 7, 32'h11111111, 32'h11111111, 0);
    tbl[7]  = mk(1, 1, 7,  32'h22222222, 1, 7, 1, 7, 32'h22222222, 32'h22222222, 0);
    tbl[8]  = mk(1, 0, 0,  32'h0,        1, 7, 1, 7, 32'h22222222, 32'h22222222, 0);
    tbl[9]  = mk(1, 0, 0,  32'h0,        1, 3, 1, 5, 32'h0,        32'hDEADBEEF, 0);
    tbl[10] = mk(1, 1, 9,  32'h12345678, 1, 9, 0, 9, 32'h12345678, 32'h0,        0);
    tbl[11] = mk(1, 0, 0,  32'h0,        1, 9, 1, 7, 32'h12345678, 32'h22222222, 0);
    tbl[12] = mk(1, 1, 9,  32'h0BADF00D, 1, 9, 1, 0, 32'h0BADF00D, 32'h0,        0);
    // Reset in RUN with a write and reads present: reads forced to 0, write lost.
    tbl[13] = mk(0, 1, 4,  32'hCAFEF00D, 1, 9, 1, 4, 32'h0,        32'h0,        0);

    // Reset for 3 cycles, with a read requested to check reads are gated.
    idle(); rst = 0; re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 31;
    repeat (3) cyc();
    chk("reset_busy", {31'b0, init_busy}, 32'h1);

    // Release; try a dropped write to r3 during INIT.
    idle(); we = 1; waddr = 3; wdata = 32'hA5A5A5A5; re1 = 1; raddr1 = 3;
    count_init(n);
    chk("init_len", n, 32);

    idle();
    for (int a = 0; a < 32; a++) begin
      re1 = 1; raddr1 = a[4:0]; re2 = 1; raddr2 = 5'(31 - a);
      #1;
      chk("clear_rd1", rdata1, 32'h0);
      chk("clear_rd2", rdata2, 32'h0);
      cyc();
    end

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      re1 = tbl[i].re1; raddr1 = tbl[i].ra1; re2 = tbl[i].re2; raddr2 = tbl[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rdata1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), rdata2, tbl[i].e2);
      chk($sformatf("vec%0d_busy", i), {31'b0, init_busy}, {31'b0, tbl[i].eb});
      cyc();
    end

    // After the RUN reset, re-reset at cnt=10 of the new clear.
    idle();
    repeat (10) cyc();
    chk("mid_init_busy", {31'b0, init_busy}, 32'h1);
    rst = 0; cyc();
    idle();
    count_init(n);
    chk("restart_len", n, 32);
    re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 4;
    #1;
    chk("r9_cleared", rdata1, 32'h0);
    chk("r4_lost", rdata2, 32'h0);
    cyc();

    // Random traffic with rare resets; bias read addresses toward the write address.
    for (int k = 0; k < 600; k++) begin
      rst    = ($urandom_range(0, 99) != 0);
      we     = $urandom_range(0, 1);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 3) != 0);
      re2    = ($urandom_range(0, 3) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
